// File: rtl/alu_trace_monitor.sv
// -----------------------------------------------------------------------------
// alu_trace_monitor
//
// Watches the ALU result bus and its N/Z flags and records every change, with
// a free-running timestamp, into an on-chip trace FIFO. Records are drained
// through a show-ahead pop interface.
//
// Optional feature: define ALU_TRACE_TRIGGER_EN to add a masked-compare start
// trigger (ports trig_value / trig_mask and a WAIT state).
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   alu_result   in   ALU result under observation            [DATA_W]
//   NegativeFlag in   ALU negative flag
//   ZeroFlag     in   ALU zero flag
//   capture_en   in   capture enable, level-sensitive
//   trig_value   in   trigger compare value (trigger build)   [DATA_W]
//   trig_mask    in   trigger compare mask  (trigger build)   [DATA_W]
//   rd_en        in   pop request
//   rd_valid     out  head entry valid (FIFO not empty)
//   rd_data      out  head entry {ts, N, Z, result}           [TS_W+2+DATA_W]
//   count        out  entries held                            [$clog2(DEPTH)+1]
//   overflow     out  sticky: at least one record was dropped
//   drop_cnt     out  dropped records, saturating             [DROP_W]
// -----------------------------------------------------------------------------
module alu_trace_monitor #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int DROP_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             alu_result,
    input  logic                          NegativeFlag,
    input  logic                          ZeroFlag,
    input  logic                          capture_en,
`ifdef ALU_TRACE_TRIGGER_EN
    input  logic [DATA_W-1:0]             trig_value,
    input  logic [DATA_W-1:0]             trig_mask,
`endif
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [TS_W+2+DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TS_W + 2 + DATA_W;

`ifdef ALU_TRACE_TRIGGER_EN
    typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [TS_W-1:0]     ts;
    logic [DATA_W-1:0]   prev_result;
    logic [1:0]          prev_flags;
    logic                seen_q;       // a RUN cycle has already been observed
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [RW-1:0]       mem [DEPTH];

    logic                in_run;
    logic                event_fire;
    logic                full, empty;
    logic                push, pop, drop;
    logic [1:0]          flags;

    assign flags = {NegativeFlag, ZeroFlag};
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

`ifdef ALU_TRACE_TRIGGER_EN
    logic trig_hit;
    assign trig_hit = ((alu_result & trig_mask) == (trig_value & trig_mask));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        in_run  = 1'b0;
        case (state_q)
            IDLE: if (capture_en) state_d = WAIT;
            WAIT: begin
                if (!capture_en) state_d = IDLE;
                else if (trig_hit) begin
                    state_d = RUN;
                    in_run  = 1'b1;   // the matching cycle is the first RUN cycle
                end
            end
            RUN: begin
                in_run = 1'b1;
                if (!capture_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`else
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        in_run  = 1'b0;
        case (state_q)
            IDLE: if (capture_en) state_d = RUN;
            RUN: begin
                in_run = 1'b1;
                if (!capture_en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
`endif

    // ------------------------------------------------------- event detection
    // The first RUN cycle after any non-RUN cycle records unconditionally.
    assign event_fire = in_run &&
                        (!seen_q || (alu_result != prev_result) || (flags != prev_flags));

    assign pop  = rd_en && !empty;
    assign push = event_fire && (!full || pop);
    assign drop = event_fire && full && !pop;

    // ------------------------------------------------------- control state
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            ts          <= '0;
            prev_result <= '0;
            prev_flags  <= '0;
            seen_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            ts     <= ts + 1'b1;
            seen_q <= in_run;
            if (in_run) begin
                prev_result <= alu_result;
                prev_flags  <= flags;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {DROP_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------- trace storage
    // NOTE: the storage array has no reset; emptiness is tracked by count and
    // the read port is gated by rd_valid, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ts, flags, alu_result};
    end

    assign rd_valid = !empty;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

endmodule
